// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mul_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Iteration counter width. It is never allowed to drop to zero bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_seq_dp.sv
// Multiplier datapath: operand magnitudes, 2W accumulator, shifter, final sign fix-up.
// Latency: one partial product per step; the result registers load on finish.
// Backpressure: none; the controller sequences load/step/finish.
module mul_seq_dp
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             finish_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // The multiplicand is held at 2W bits so that shifting it left each step
  // gives mag_a << cnt without a barrel shifter.
  logic [2*WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] result;

  // Magnitude is taken only for signed operands with the sign bit set.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    abs_a = (is_signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    abs_b = (is_signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
  end

  // Apply the product sign over the full 2W bits.
  assign result = neg_q ? (~acc_q + 1'b1) : acc_q;

  // Next-state for the operand, accumulator and result registers.
  always_comb begin
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (load_i) begin
      mag_a_d = {{WIDTH{1'b0}}, abs_a};
      mag_b_d = abs_b;
      neg_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      acc_d   = '0;
    end else if (step_i) begin
      if (mag_b_q[0]) begin
        acc_d = acc_q + mag_a_q;
      end
      mag_a_d = mag_a_q << 1;
      mag_b_d = mag_b_q >> 1;
    end
    if (finish_i) begin
      hi_d = result[2*WIDTH-1:WIDTH];
      lo_d = result[WIDTH-1:0];
    end
  end

  // Datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential signed/unsigned multiplier: FSM, iteration counter and start/busy/done handshake.
// Latency: hi/lo and done update WIDTH+1 edges after the edge that samples start.
// Backpressure: start is ignored while busy (no queueing); cancel aborts and leaves hi/lo unchanged.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          load, step, finish;

  // Next-state and datapath strobes. Cancel beats both a pending step and FIN completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!cancel) begin
          finish = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = finish;
  end

  // State, counter and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  mul_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (step),
    .finish_i   (finish),
    .is_signed_i(is_signed),
    .a_i        (a),
    .b_i        (b),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl.
// Latency: checks done at exactly WIDTH+1 edges after the start-sampling edge.
// Backpressure: exercises start-while-busy, cancel and asynchronous reset.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial forever #5 clk = ~clk;

  // Called at a negedge: presents a one-cycle start, returns at the negedge after the sampling edge.
  task automatic do_start(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; is_signed = s; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done (bounded); cyc=-1 on timeout. Also counts busy-high samples.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    while (cyc < 100 && !done) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic;
    int cyc, bc;
    do_start(1'b0, 32'd9, 32'd12);
    wait_done(cyc, bc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL u9x12_latency got=%0d exp=33", cyc); end
    total++; if (bc !== 33) begin bad++; $display("FAIL u9x12_busy_cycles got=%0d exp=33", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL u9x12_busy_at_done got=%b exp=0", busy); end
    total++; if (hi !== 32'h0 || lo !== 32'h6C) begin bad++; $display("FAIL u9x12_result got=%h_%h exp=00000000_0000006c", hi, lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL u9x12_done_pulse got=%b exp=0", done); end
    total++; if (lo !== 32'h6C) begin bad++; $display("FAIL u9x12_hold got=%h exp=0000006c", lo); end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    do_start(1'b1, 32'hFFFFFFFE, 32'd12);
    wait_done(cyc, bc);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE8) begin bad++; $display("FAIL s_m2x12 got=%h_%h exp=ffffffff_ffffffe8", hi, lo); end
    // start presented in the done cycle
    do_start(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(cyc, bc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", cyc); end
    total++; if (hi !== 32'h0 || lo !== 32'h4) begin bad++; $display("FAIL s_m2xm2 got=%h_%h exp=00000000_00000004", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_edge_operands;
    int cyc, bc;
    do_start(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    wait_done(cyc, bc);
    total++; if (hi !== 32'hFFFFFFFC || lo !== 32'h4) begin bad++; $display("FAIL u_max got=%h_%h exp=fffffffc_00000004", hi, lo); end
    @(negedge clk);
    do_start(1'b1, 32'h80000000, 32'h80000000);
    wait_done(cyc, bc);
    total++; if (hi !== 32'h40000000 || lo !== 32'h0) begin bad++; $display("FAIL s_min got=%h_%h exp=40000000_00000000", hi, lo); end
    @(negedge clk);
    do_start(1'b1, 32'h0, 32'hFFFFFFFB);
    wait_done(cyc, bc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL zero_latency got=%0d exp=33", cyc); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL zero_result got=%h_%h exp=0", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    int first = -1;
    do_start(1'b0, 32'd9, 32'd12);
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin start = 1'b1; a = 32'd5; b = 32'd5; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    total++; if (first !== 33) begin bad++; $display("FAIL ignore_latency got=%0d exp=33", first); end
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", dones); end
    total++; if (hi !== 32'h0 || lo !== 32'h6C) begin bad++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000006c", hi, lo); end
  endtask

  task automatic test_cancel;
    int dones = 0;
    int cyc, bc;
    do_start(1'b0, 32'd5, 32'd5);
    repeat (19) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL cancel_no_done got=%0d exp=0", dones); end
    total++; if (hi !== 32'h0 || lo !== 32'h6C) begin bad++; $display("FAIL cancel_hold got=%h_%h exp=00000000_0000006c", hi, lo); end
    do_start(1'b0, 32'd5, 32'd5);
    wait_done(cyc, bc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL after_cancel_latency got=%0d exp=33", cyc); end
    total++; if (hi !== 32'h0 || lo !== 32'h19) begin bad++; $display("FAIL after_cancel_result got=%h_%h exp=00000000_00000019", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int cyc, bc;
    do_start(1'b0, 32'd7, 32'd3);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL arst_hilo got=%h_%h exp=0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_idle got=%b exp=0", busy); end
    do_start(1'b0, 32'd7, 32'd3);
    wait_done(cyc, bc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL arst_next_latency got=%0d exp=33", cyc); end
    total++; if (hi !== 32'h0 || lo !== 32'h15) begin bad++; $display("FAIL arst_next_result got=%h_%h exp=00000000_00000015", hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_back_to_back();
    test_edge_operands();
    test_start_while_busy();
    test_cancel();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
